// File: rtl/mult_seq_if.sv
// Handshake and product-register bus between the shift-add multiplier
// controller and its surroundings (sequencer + double-wide product register).
interface mult_seq_if #(
  parameter int N = 16
);
  localparam int W = N / 2;

  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic [N-1:0] prod;
  logic [W-1:0] inh;
  logic [W-1:0] inl;
  logic         loadh;
  logic         loadl;
  logic         busy;
  logic         done;

  modport master (
    output start, multiplicand, multiplier, prod,
    input  inh, inl, loadh, loadl, busy, done
  );

  modport slave (
    input  start, multiplicand, multiplier, prod,
    output inh, inl, loadh, loadl, busy, done
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Controller and adder datapath for a sequential shift-add unsigned multiplier.
// Drives the next high/low halves into an external product register and reads
// its contents back on prod, doing one add-and-shift per multiplier bit.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | waiting for start; operands captured on the accepting edge
// INIT      | load {0, multiplier} into the product register, clear cnt
// ADD_SHIFT | conditional add of multiplicand into high half, shift right
// DONE      | one-cycle done pulse; prod holds the full product
module mult_seq_ctrl #(
  parameter int N = 16
) (
  input  logic     clk,
  input  logic     clear,
  mult_seq_if.slave bus
);
  localparam int W  = N / 2;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INIT      = 2'd1,
    ADD_SHIFT = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  mcand_r;
  logic [W-1:0]  mplier_r;

  logic [W-1:0]  h, l;
  logic [W:0]    sum;
  logic [W-1:0]  inh_c, inl_c;
  logic          loadh_c, loadl_c, busy_c, done_c;

  assign h = bus.prod[N-1:W];
  assign l = bus.prod[W-1:0];

  // State register, step counter and operand capture; clear aborts any operation.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      cnt      <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && bus.start) begin
        mcand_r  <= bus.multiplicand;
        mplier_r <= bus.multiplier;
      end
      if (state == INIT)
        cnt <= '0;
      else if (state == ADD_SHIFT)
        cnt <= cnt + 1'b1;
    end
  end

  // Next-state and output decode; the W+1-bit sum carries the adder overflow
  // straight into the shifted high half, so no carry flop is required.
  always_comb begin
    next_state = state;
    inh_c      = '0;
    inl_c      = '0;
    loadh_c    = 1'b0;
    loadl_c    = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    sum        = '0;
    case (state)
      IDLE: begin
        if (bus.start) next_state = INIT;
      end
      INIT: begin
        loadh_c    = 1'b1;
        loadl_c    = 1'b1;
        inl_c      = mplier_r;
        busy_c     = 1'b1;
        next_state = ADD_SHIFT;
      end
      ADD_SHIFT: begin
        sum     = l[0] ? ({1'b0, h} + {1'b0, mcand_r}) : {1'b0, h};
        inh_c   = sum[W:1];
        inl_c   = {sum[0], l[W-1:1]};
        loadh_c = 1'b1;
        loadl_c = 1'b1;
        busy_c  = 1'b1;
        if (cnt == LAST) next_state = DONE;
      end
      DONE: begin
        done_c     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.inh   = inh_c;
  assign bus.inl   = inl_c;
  assign bus.loadh = loadh_c;
  assign bus.loadl = loadl_c;
  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
endmodule
